nvram_upload_reader: RTL and testbench

Streams a fixed region of core work RAM (hiscore/NVRAM area) to the HPS over the ioctl upload channel, i.e. the core-to-HPS counterpart of the ROM download path. It sits in the emu top next to hps_io and the game core. It requests an upload on a save trigger, pauses the CPU for the transfer, and serves each HPS byte read through a wait-stretched RAM fetch.

---
 rtl/nvram_upload_pkg.sv | 28 ++
 rtl/crc16_ccitt_byte.sv | 18 +
 rtl/nvram_upload_reader.sv | 209 ++++++++++++++++++++
 tb/tb_nvram_upload_reader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvram_upload_pkg.sv
// nvram_upload_pkg: shared types and helpers for the NVRAM upload reader.
//   - state_e      : byte-serve FSM states
//   - CRC16_POLY   : CRC-16/CCITT polynomial
//   - CRC16_INIT   : CRC-16/CCITT-FALSE initial value
//   - crc16_byte() : folds one byte into a CRC-16/CCITT-FALSE value (MSB first)
package nvram_upload_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StFetch,
    StWait,
    StPresent
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data_byte);
    logic [15:0] c;
    c = crc ^ {data_byte, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// crc16_ccitt_byte: combinational one-byte step of CRC-16/CCITT-FALSE.
// Ports:
//   crc_i  [15:0] current CRC value
//   data_i [7:0]  byte to fold in
//   crc_o  [15:0] CRC after folding in data_i
module crc16_ccitt_byte
  import nvram_upload_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    crc_o = crc16_byte(crc_i, data_i);
  end

endmodule

// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader: streams a fixed work-RAM region (hiscore/NVRAM) to the HPS
// over the ioctl upload channel.
// Optional feature macro: NVRAM_UPLOAD_CRC_EN (appends a 2-byte CRC-16 trailer).
// Ports:
//   clk_sys, RESET_n          clock, synchronous active-low reset
//   save_trig                 pulse requesting an upload
//   ioctl_upload/_index/_rd/_addr   HPS upload channel inputs
//   ioctl_upload_req          one-cycle upload request to hps_io
//   ioctl_din, ioctl_wait     byte returned to the HPS and hold-off strobe
//   pause_req, pause_ack      CPU pause handshake guarding the RAM port
//   ram_addr, ram_rd, ram_q   RAM read port
module nvram_upload_reader
  import nvram_upload_pkg::*;
#(
  parameter logic [7:0]  INDEX       = 8'd4,
  parameter int unsigned AW          = 16,
  parameter logic [AW-1:0] REGION_BASE = '0,
  parameter int unsigned REGION_LEN  = 256,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic          clk_sys,
  input  logic          RESET_n,
  input  logic          save_trig,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic          ioctl_upload_req,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q
);

  localparam logic [24:0] LenW = 25'(REGION_LEN);
  localparam logic [1:0]  Lat  = 2'(RAM_LATENCY);

  logic          active;
  state_e        state_q, state_d;
  logic [24:0]   addr_q, addr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          trig_q;
  logic          req_q, req_d;
  logic          pause_q;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_rd_q, ram_rd_d;
  logic          in_range;
  logic [7:0]    oor_byte;

  assign active   = ioctl_upload && (ioctl_index == INDEX);
  assign in_range = addr_q < LenW;

`ifdef NVRAM_UPLOAD_CRC_EN
  logic [15:0] crc_q, crc_d, crc_seed, crc_next;
  logic [24:0] next_q, next_d;
  logic        bad_q, bad_d;
  logic        capture;

  // Address 0 restarts the checksum, so seed from INIT rather than the running value.
  assign crc_seed = (addr_q == '0) ? CRC16_INIT : crc_q;
  assign capture  = active && (state_q == StWait) && (cnt_q == Lat);

  crc16_ccitt_byte u_crc (
    .crc_i  (crc_seed),
    .data_i (ram_q),
    .crc_o  (crc_next)
  );

  always_comb begin
    crc_d  = crc_q;
    next_d = next_q;
    bad_d  = bad_q;
    if (capture) begin
      if (addr_q == '0) begin
        crc_d  = crc_next;
        next_d = 25'd1;
        bad_d  = 1'b0;
      end else if (addr_q == next_q) begin
        crc_d  = crc_next;
        next_d = next_q + 25'd1;
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_comb begin
    oor_byte = 8'h00;
    if (!bad_q) begin
      if (addr_q == LenW) begin
        oor_byte = crc_q[15:8];
      end else if (addr_q == LenW + 25'd1) begin
        oor_byte = crc_q[7:0];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      crc_q  <= CRC16_INIT;
      next_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      crc_q  <= crc_d;
      next_q <= next_d;
      bad_q  <= bad_d;
    end
  end
`else
  assign oor_byte = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    din_d      = din_q;
    wait_d     = wait_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    // Rising edge only, and never while an upload is already running.
    req_d      = save_trig && !trig_q && !active;

    if (state_q != StIdle && !active) begin
      // Upload dropped mid-read: abandon the byte, keep the last presented value.
      state_d = StIdle;
      wait_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ioctl_rd && active) begin
            addr_d  = ioctl_addr;
            wait_d  = 1'b1;
            state_d = StArb;
          end
        end
        StArb: begin
          if (pause_ack) begin
            if (in_range) begin
              ram_addr_d = REGION_BASE + addr_q[AW-1:0];
              ram_rd_d   = 1'b1;
              state_d    = StFetch;
            end else begin
              din_d   = oor_byte;
              state_d = StPresent;
            end
          end
        end
        StFetch: begin
          // ram_rd is high this cycle; data lands Lat cycles from now.
          cnt_d   = 2'd1;
          state_d = StWait;
        end
        StWait: begin
          if (cnt_q == Lat) begin
            din_d   = ram_q;
            state_d = StPresent;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        StPresent: begin
          wait_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      req_q      <= 1'b0;
      pause_q    <= 1'b0;
      din_q      <= 8'h00;
      wait_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      trig_q     <= save_trig;
      req_q      <= req_d;
      pause_q    <= active;
      din_q      <= din_d;
      wait_q     <= wait_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
    end
  end

  assign ioctl_upload_req = req_q;
  assign ioctl_din        = din_q;
  assign ioctl_wait       = wait_q;
  assign pause_req        = pause_q;
  assign ram_addr         = ram_addr_q;
  assign ram_rd           = ram_rd_q;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench for nvram_upload_reader (REGION_BASE 0x0100, REGION_LEN 9, RAM_LATENCY 2).
// Trailer checks depend on NVRAM_UPLOAD_CRC_EN matching the DUT build.
module tb_nvram_upload_reader;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic        save_trig;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        ioctl_upload_req;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;

  logic [7:0] mem [0:65535];
  logic [7:0] pipe0, pipe1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  // Two-stage RAM model: data for a ram_rd at cycle c is on ram_q at c+2.
  always @(posedge clk_sys) begin
    if (ram_rd) pipe0 <= mem[ram_addr];
    pipe1 <= pipe0;
  end
  assign ram_q = pipe1;

  nvram_upload_reader #(
    .INDEX       (8'd4),
    .AW          (16),
    .REGION_BASE (16'h0100),
    .REGION_LEN  (9),
    .RAM_LATENCY (2)
  ) dut (
    .clk_sys          (clk_sys),
    .RESET_n          (RESET_n),
    .save_trig        (save_trig),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_upload_req (ioctl_upload_req),
    .ioctl_din        (ioctl_din),
    .ioctl_wait       (ioctl_wait),
    .pause_req        (pause_req),
    .pause_ack        (pause_ack),
    .ram_addr         (ram_addr),
    .ram_rd           (ram_rd),
    .ram_q            (ram_q)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Issue one read and follow it until ioctl_wait drops (bounded).
  // wc = cycles with ioctl_wait high, ro = cycle offset of ram_rd (-1 if none).
  task automatic do_read(input logic [24:0] a, output logic [7:0] d, output int wc,
                         output int ro);
    int k;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    wc = 0;
    ro = -1;
    k  = 1;
    while (ioctl_wait && wc < 50) begin
      if (ram_rd && ro < 0) ro = k;
      wc++;
      tick();
      k++;
    end
    d = ioctl_din;
  endtask

  task automatic load_seq();
    mem[16'h0100] = 8'hA5;
    mem[16'h0101] = 8'h5A;
    mem[16'h0102] = 8'hFF;
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ioctl_upload_req, ioctl_wait, pause_req, ram_rd} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0000",
               {ioctl_upload_req, ioctl_wait, pause_req, ram_rd});
    end
    n_checks++;
    if (ioctl_din !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_din: got %h want 00", ioctl_din);
    end
    n_checks++;
    if (ram_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_ram_addr: got %h want 0000", ram_addr);
    end
    RESET_n = 1'b1;
    tick();
  endtask

  task automatic test_request();
    save_trig = 1'b1;
    tick();
    save_trig = 1'b0;
    n_checks++;
    if (ioctl_upload_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_pulse: got %b want 1", ioctl_upload_req);
    end
    tick();
    n_checks++;
    if (ioctl_upload_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_single_cycle: got %b want 0", ioctl_upload_req);
    end
    ioctl_upload = 1'b1;
    tick();
    n_checks++;
    if (pause_req !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_req_active: got %b want 1", pause_req);
    end
    save_trig = 1'b1;
    tick();
    save_trig = 1'b0;
    n_checks++;
    if (ioctl_upload_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_while_active: got %b want 0", ioctl_upload_req);
    end
    tick();
  endtask

  task automatic test_seq_read();
    logic [7:0] exp_d [3];
    logic [7:0] d;
    int wc, ro;
    exp_d[0] = 8'hA5;
    exp_d[1] = 8'h5A;
    exp_d[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      do_read(25'(i), d, wc, ro);
      n_checks++;
      if (d !== exp_d[i]) begin
        n_fail++;
        $display("FAIL seq_data[%0d]: got %h want %h", i, d, exp_d[i]);
      end
      n_checks++;
      if (wc !== 5) begin
        n_fail++;
        $display("FAIL seq_wait_len[%0d]: got %0d want 5", i, wc);
      end
      n_checks++;
      if (ro !== 2) begin
        n_fail++;
        $display("FAIL seq_ram_rd_offset[%0d]: got %0d want 2", i, ro);
      end
      tick();
    end
  endtask

  task automatic test_pause_gating();
    int bad;
    int wc;
    pause_ack  = 1'b0;
    ioctl_addr = 25'd1;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (ioctl_wait !== 1'b1 || ram_rd !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL pause_hold: got %0d bad cycles want 0", bad);
    end
    pause_ack = 1'b1;
    tick();
    n_checks++;
    if ({ram_rd, ioctl_wait} !== 2'b11) begin
      n_fail++;
      $display("FAIL pause_release: got rd/wait %b want 11", {ram_rd, ioctl_wait});
    end
    wc = 0;
    while (ioctl_wait && wc < 50) begin
      wc++;
      tick();
    end
    n_checks++;
    if (ioctl_din !== 8'h5A) begin
      n_fail++;
      $display("FAIL pause_data: got %h want 5a", ioctl_din);
    end
    tick();
  endtask

  task automatic test_range();
    logic [7:0] d;
    int wc, ro;
    do_read(25'd2, d, wc, ro);
    do_read(25'd14, d, wc, ro);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL range_data: got %h want 00", d);
    end
    n_checks++;
    if (wc !== 2) begin
      n_fail++;
      $display("FAIL range_wait_len: got %0d want 2", wc);
    end
    n_checks++;
    if (ro !== -1) begin
      n_fail++;
      $display("FAIL range_no_ram_rd: got %0d want -1", ro);
    end
    tick();
  endtask

  task automatic test_trailer();
    logic [7:0] d;
    int wc, ro;
    for (int i = 0; i < 9; i++) mem[16'h0100 + 16'(i)] = 8'h31 + 8'(i);
    for (int i = 0; i < 9; i++) do_read(25'(i), d, wc, ro);
`ifdef NVRAM_UPLOAD_CRC_EN
    do_read(25'd9, d, wc, ro);
    n_checks++;
    if (d !== 8'h29) begin
      n_fail++;
      $display("FAIL crc_hi: got %h want 29", d);
    end
    n_checks++;
    if (wc !== 2) begin
      n_fail++;
      $display("FAIL crc_wait_len: got %0d want 2", wc);
    end
    do_read(25'd10, d, wc, ro);
    n_checks++;
    if (d !== 8'hB1) begin
      n_fail++;
      $display("FAIL crc_lo: got %h want b1", d);
    end
    do_read(25'd3, d, wc, ro);
    n_checks++;
    if (d !== 8'h34) begin
      n_fail++;
      $display("FAIL crc_reread: got %h want 34", d);
    end
    do_read(25'd9, d, wc, ro);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL crc_bad_hi: got %h want 00", d);
    end
    do_read(25'd10, d, wc, ro);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL crc_bad_lo: got %h want 00", d);
    end
`else
    do_read(25'd9, d, wc, ro);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL trailer_hi_off: got %h want 00", d);
    end
    do_read(25'd3, d, wc, ro);
    do_read(25'd10, d, wc, ro);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL trailer_lo_off: got %h want 00", d);
    end
`endif
    load_seq();
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] prev;
    prev       = ioctl_din;
    ioctl_addr = 25'd0;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    tick();
    ioctl_upload = 1'b0;
    tick();
    n_checks++;
    if ({ioctl_wait, pause_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_next: got wait/pause %b want 00", {ioctl_wait, pause_req});
    end
    n_checks++;
    if (ioctl_din !== prev) begin
      n_fail++;
      $display("FAIL abort_din_hold: got %h want %h", ioctl_din, prev);
    end
    tick();
    tick();
    n_checks++;
    if ({ioctl_wait, pause_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_settled: got wait/pause %b want 00", {ioctl_wait, pause_req});
    end
    ioctl_upload = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int wc, ro;
    do_read(25'd0, d, wc, ro);
    ioctl_addr = 25'd2;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    RESET_n = 1'b0;
    tick();
    n_checks++;
    if ({ioctl_wait, ram_rd, pause_req, ioctl_upload_req} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_strobes: got %b want 0000",
               {ioctl_wait, ram_rd, pause_req, ioctl_upload_req});
    end
    n_checks++;
    if ({ioctl_din, ram_addr} !== 24'h000000) begin
      n_fail++;
      $display("FAIL midreset_regs: got din %h addr %h want 00 0000", ioctl_din, ram_addr);
    end
    RESET_n = 1'b1;
    tick();
    tick();
    do_read(25'd1, d, wc, ro);
    n_checks++;
    if (d !== 8'h5A || wc !== 5) begin
      n_fail++;
      $display("FAIL after_reset_read: got %h/%0d want 5a/5", d, wc);
    end
  endtask

  initial begin
    RESET_n      = 1'b0;
    save_trig    = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd4;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    pause_ack    = 1'b1;
    pipe0        = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    load_seq();

    test_reset();
    test_request();
    test_seq_read();
    test_pause_gating();
    test_range();
    test_trailer();
    test_abort();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
